// File: rtl/aes_tx_scheduler.sv
// aes_tx_scheduler
// Sits between the AES core and the UART transmitter. A start request launches
// one AES block encryption, the 128-bit ciphertext is captured into a shift
// register and streamed to the UART one byte at a time (most significant byte
// first) using a start/busy handshake. Completion or AES timeout is reported.
//
// Build option: define SYNC_HEADER_EN to prepend HEADER_BYTE to every frame
// (17-byte frame instead of 16).
//
// Ports
//   clk            in   system clock, rising edge
//   reset          in   asynchronous reset, active low
//   start          in   encrypt-and-send request, sampled in IDLE only
//   aes_start      out  one-cycle pulse launching the AES core
//   aes_done       in   AES result valid, aes_dout stable in the same cycle
//   aes_dout       in   128-bit ciphertext
//   uart_tx_start  out  one-cycle pulse requesting transmission of uart_tx_data
//   uart_tx_data   out  byte to transmit, held until the next byte is launched
//   uart_tx_busy   in   UART transmitting
//   busy           out  high whenever the scheduler is not idle
//   done           out  one-cycle pulse after the last byte completes
//   error          out  one-cycle pulse on AES timeout
//   byte_count     out  bytes fully transmitted in the current frame
module aes_tx_scheduler #(
  parameter int          AES_TIMEOUT = 1024,
  parameter logic [7:0]  HEADER_BYTE = 8'hA5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          aes_start,
  input  logic          aes_done,
  input  logic [127:0]  aes_dout,
  output logic          uart_tx_start,
  output logic [7:0]    uart_tx_data,
  input  logic          uart_tx_busy,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [4:0]    byte_count
);

  localparam int CNT_W = (AES_TIMEOUT > 1) ? $clog2(AES_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AES_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

`ifdef SYNC_HEADER_EN
  localparam logic [4:0] FRAME_LEN = 5'd17;
`else
  localparam logic [4:0] FRAME_LEN = 5'd16;
`endif

  typedef enum logic [2:0] {
    IDLE, AES_REQ, AES_WAIT, SEND, ACK, DRAIN, FINISH
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_inc;
  logic [127:0]     shift_reg;
  logic             header_slot;
  logic             last_byte;
  logic [7:0]       tx_byte;

  // Saturating increment: the counter may never wrap back to zero.
  assign cnt_inc = (cnt_reg == CNT_SAT) ? cnt_reg : cnt_reg + CNT_W'(1);

  // With the header enabled, frame slot 0 carries the header and the
  // ciphertext only starts shifting out from slot 1.
`ifdef SYNC_HEADER_EN
  assign header_slot = (byte_count == 5'd0);
`else
  assign header_slot = 1'b0;
`endif

  assign tx_byte   = header_slot ? HEADER_BYTE : shift_reg[127:120];
  assign last_byte = (byte_count == FRAME_LEN - 5'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      shift_reg     <= '0;
      aes_start     <= 1'b0;
      uart_tx_start <= 1'b0;
      uart_tx_data  <= 8'h00;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      byte_count    <= 5'd0;
    end else begin
      // Pulse outputs default low; each is raised for exactly one cycle below.
      aes_start     <= 1'b0;
      uart_tx_start <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            aes_start <= 1'b1;
            busy      <= 1'b1;
            state_reg <= AES_REQ;
          end
        end
        AES_REQ: begin
          cnt_reg   <= '0;
          state_reg <= AES_WAIT;
        end
        AES_WAIT: begin
          // A result arriving on the timeout cycle takes priority.
          if (aes_done) begin
            shift_reg  <= aes_dout;
            byte_count <= 5'd0;
            state_reg  <= SEND;
          end else if (cnt_inc == CNT_LAST) begin
            error     <= 1'b1;
            busy      <= 1'b0;
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_inc;
          end
        end
        SEND: begin
          if (!uart_tx_busy) begin
            uart_tx_start <= 1'b1;
            uart_tx_data  <= tx_byte;
            state_reg     <= ACK;
          end
        end
        ACK: begin
          if (uart_tx_busy) state_reg <= DRAIN;
        end
        DRAIN: begin
          if (!uart_tx_busy) begin
            byte_count <= byte_count + 5'd1;
            if (last_byte) begin
              // done is raised here so it appears in the cycle right after
              // the final busy fall; busy drops one cycle later.
              done      <= 1'b1;
              state_reg <= FINISH;
            end else begin
              if (!header_slot) shift_reg <= {shift_reg[119:0], 8'h00};
              state_reg <= SEND;
            end
          end
        end
        FINISH: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_tx_scheduler.sv
// Bench for aes_tx_scheduler: behavioural AES and UART models, a byte
// scoreboard and a table of frame scenarios plus a mid-frame reset sequence.
module tb_aes_tx_scheduler;

  localparam int AES_TIMEOUT = 1024;
`ifdef SYNC_HEADER_EN
  localparam int FRAME = 17;
`else
  localparam int FRAME = 16;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         aes_start;
  logic         aes_done;
  logic [127:0] aes_dout;
  logic         uart_tx_start;
  logic [7:0]   uart_tx_data;
  logic         uart_tx_busy;
  logic         busy;
  logic         done;
  logic         error;
  logic [4:0]   byte_count;

  aes_tx_scheduler #(.AES_TIMEOUT(AES_TIMEOUT), .HEADER_BYTE(8'hA5)) dut (
    .clk(clk), .reset(reset), .start(start),
    .aes_start(aes_start), .aes_done(aes_done), .aes_dout(aes_dout),
    .uart_tx_start(uart_tx_start), .uart_tx_data(uart_tx_data),
    .uart_tx_busy(uart_tx_busy), .busy(busy), .done(done), .error(error),
    .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model / monitor state (written by the negedge process, configured by main
  // only between clock edges at posedge+2).
  logic [7:0]   sb_q[$];
  int           cyc = 0;
  int           aes_latency = 20;
  logic [127:0] aes_value = '0;
  bit           aes_pending = 0;
  int           aes_wait_cnt = 0;
  int           uart_hold = 10;
  int           uart_busy_cnt = 0;
  bit           uart_own = 0;
  logic [7:0]   cur_byte = 8'h00;
  int           last_fall = -10;
  int           done_cnt = 0, error_cnt = 0, aes_start_cnt = 0, tx_cnt = 0;
  int           aes_start_cyc = 0, error_cyc = 0, aes_done_cyc = 0;
  bit           first_start_pending = 0;
  bit           done_prev = 0, error_prev = 0;

  task automatic push_frame(input logic [127:0] data);
`ifdef SYNC_HEADER_EN
    sb_q.push_back(8'hA5);
`endif
    for (int i = 15; i >= 0; i--) sb_q.push_back(data[i*8 +: 8]);
  endtask

  initial begin : models
    aes_done = 1'b0;
    aes_dout = '0;
    uart_tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      // ---- monitor ----
      if (aes_start) begin aes_start_cnt++; aes_start_cyc = cyc; end
      if (error) begin error_cnt++; error_cyc = cyc; end
      if (done) begin
        done_cnt++;
        check("done_timing", cyc, last_fall + 1);
        check("done_byte_count", byte_count, FRAME);
        check("busy_during_done", busy, 1);
      end
      if (done_prev) check("busy_after_done", busy, 0);
      if (error_prev) check("busy_after_error", busy, 0);
      done_prev = done;
      error_prev = error;
      // ---- AES model ----
      aes_done = 1'b0;
      aes_dout = {$urandom, $urandom, $urandom, $urandom};
      if (aes_pending) begin
        if (aes_wait_cnt == aes_latency) begin
          aes_done = 1'b1;
          aes_dout = aes_value;
          aes_pending = 0;
          aes_done_cyc = cyc;
          first_start_pending = 1;
        end
        aes_wait_cnt++;
      end
      if (aes_start && aes_latency >= 0) begin
        aes_pending = 1;
        aes_wait_cnt = 1;
      end
      // ---- UART model ----
      if (uart_busy_cnt > 0) begin
        if (uart_own) check("tx_data_stable", uart_tx_data, cur_byte);
        uart_busy_cnt--;
        if (uart_busy_cnt == 0) begin
          uart_tx_busy = 1'b0;
          last_fall = cyc;
        end
      end
      if (uart_tx_start) begin
        check("start_while_busy", uart_tx_busy, 0);
        if (first_start_pending) begin
          check("first_byte_latency_ok", cyc >= aes_done_cyc + 2, 1);
          first_start_pending = 0;
        end
        if (sb_q.size() == 0) begin
          check("unexpected_byte", uart_tx_data, 8'hxx);
        end else begin
          check("tx_byte", uart_tx_data, sb_q.pop_front());
        end
        tx_cnt++;
        cur_byte = uart_tx_data;
        uart_own = 1;
        uart_tx_busy = 1'b1;
        uart_busy_cnt = uart_hold;
      end
    end
  end

  typedef struct {
    string        name;
    logic [127:0] data;
    int           aes_lat;
    int           hold;
    int           pre_busy;
    bit           restart;
    bit           exp_error;
  } frame_vec_t;

  frame_vec_t vecs[6];

  task automatic run_frame(input frame_vec_t v);
    int d0, e0, a0, t0, n, restart_left;
    bit restarted;
    d0 = done_cnt; e0 = error_cnt; a0 = aes_start_cnt; t0 = tx_cnt;
    aes_latency = v.aes_lat;
    aes_value = v.data;
    uart_hold = v.hold;
    if (v.pre_busy > 0) begin
      uart_tx_busy = 1'b1;
      uart_busy_cnt = v.pre_busy;
      uart_own = 0;
    end
    if (!v.exp_error) push_frame(v.data);
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    check({v.name, ":aes_start_pulse"}, aes_start, 1);
    check({v.name, ":busy_rise"}, busy, 1);
    n = 0; restarted = 0; restart_left = 0;
    while (done_cnt == d0 && error_cnt == e0 && n < 3000) begin
      @(posedge clk); #2;
      n++;
      if (v.restart) begin
        if (!restarted && tx_cnt >= t0 + 3) begin
          start = 1'b1; restart_left = 15; restarted = 1;
        end else if (restart_left > 0) begin
          restart_left--;
          if (restart_left == 0) start = 1'b0;
        end
      end
    end
    start = 1'b0;
    check({v.name, ":terminated"}, n < 3000, 1);
    repeat (4) @(posedge clk);
    #2;
    check({v.name, ":done_pulses"}, done_cnt - d0, v.exp_error ? 0 : 1);
    check({v.name, ":error_pulses"}, error_cnt - e0, v.exp_error ? 1 : 0);
    check({v.name, ":aes_starts"}, aes_start_cnt - a0, 1);
    check({v.name, ":bytes_sent"}, tx_cnt - t0, v.exp_error ? 0 : FRAME);
    check({v.name, ":sb_empty"}, sb_q.size(), 0);
    check({v.name, ":idle_busy"}, busy, 0);
    if (v.exp_error) check({v.name, ":error_latency"}, error_cyc - aes_start_cyc, AES_TIMEOUT);
    $display("frame %s: sent %0d bytes, done=%0d error=%0d", v.name, tx_cnt - t0, done_cnt - d0, error_cnt - e0);
  endtask

  initial begin : main
    int n, d0, e0;
    vecs[0] = '{"basic",       128'h00112233445566778899AABBCCDDEEFF, 20,   10, 0,  0, 0};
    vecs[1] = '{"timeout",     128'hFFFFFFFF000000001111111122222222, -1,   10, 0,  0, 1};
    vecs[2] = '{"restart",     128'hDEADBEEFCAFEF00D0123456789ABCDEF, 5,    10, 0,  1, 0};
    vecs[3] = '{"uart_busy",   128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0, 20,   10, 60, 0, 0};
    vecs[4] = '{"done_at_tmo", 128'h8001400220041008080410022001C003, 1023, 3,  0,  0, 0};
    vecs[5] = '{"fresh",       128'hA1B2C3D4E5F60718293A4B5C6D7E8F90, 7,    4,  0,  0, 0};

    reset = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst:aes_start", aes_start, 0);
    check("rst:uart_tx_start", uart_tx_start, 0);
    check("rst:uart_tx_data", uart_tx_data, 8'h00);
    check("rst:busy", busy, 0);
    check("rst:done", done, 0);
    check("rst:error", error, 0);
    check("rst:byte_count", byte_count, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 5; i++) run_frame(vecs[i]);

    // Reset after byte 5 completes, then a fresh frame must start from byte 0.
    aes_latency = 20;
    aes_value = 128'h00112233445566778899AABBCCDDEEFF;
    uart_hold = 10;
    push_frame(aes_value);
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    n = 0;
    while (byte_count != 5'd5 && n < 1000) begin
      @(posedge clk); #2;
      n++;
    end
    check("mid:reach_byte5", n < 1000, 1);
    d0 = done_cnt; e0 = error_cnt;
    reset = 1'b0;
    #1;
    check("mid:aes_start", aes_start, 0);
    check("mid:uart_tx_start", uart_tx_start, 0);
    check("mid:uart_tx_data", uart_tx_data, 8'h00);
    check("mid:busy", busy, 0);
    check("mid:done", done, 0);
    check("mid:error", error, 0);
    check("mid:byte_count", byte_count, 0);
    sb_q.delete();
    uart_busy_cnt = 0;
    uart_tx_busy = 1'b0;
    aes_pending = 0;
    first_start_pending = 0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("mid:no_done", done_cnt - d0, 0);
    check("mid:no_error", error_cnt - e0, 0);
    $display("reset mid-frame at byte 5: outputs cleared");
    run_frame(vecs[5]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_tx_scheduler.md
# aes_tx_scheduler

Control block between the AES encryption core and the UART transmitter in the TX path. On a start request it launches one AES block encryption, captures the 128-bit ciphertext, and streams it to the UART byte by byte under a start/busy handshake. It reports completion or an AES timeout to the top level.

## Interface
- `AES_TIMEOUT`, default 1024: maximum cycles to wait for `aes_done` after `aes_start`.
- `HEADER_BYTE`, default 8'hA5: frame header value; used only when `SYNC_HEADER_EN` is defined.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `start`  in  1  encrypt-and-send request; sampled only in IDLE.
- `aes_start`  out  1  one-cycle pulse launching the AES core.
- `aes_done`  in  1  AES result valid; `aes_dout` is stable in the same cycle.
- `aes_dout`  in  128  ciphertext from the AES core.
- `uart_tx_start`  out  1  one-cycle pulse requesting transmission of `uart_tx_data`.
- `uart_tx_data`  out  8  byte to transmit; held stable from the pulse until the byte completes.
- `uart_tx_busy`  in  1  UART transmitting; high from acceptance until the stop bit ends.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last byte completes.
- `error`  out  1  one-cycle pulse on AES timeout.
- `byte_count`  out  5  number of bytes fully transmitted in the current frame.

## Operation
- States: IDLE, AES_REQ, AES_WAIT, SEND, ACK, DRAIN, FINISH.
- IDLE: when `start`=1, go to AES_REQ. A start arriving in any other state is ignored and is not queued.
- AES_REQ: assert `aes_start` for one cycle, clear the timeout counter, and go to AES_WAIT.
- AES_WAIT: count cycles.
  - If `aes_done`=1, latch `aes_dout` into a 128-bit shift register, clear `byte_count`, and go to SEND.
  - If the counter reaches `AES_TIMEOUT`-1 without `aes_done`, pulse `error` and go to IDLE. `done` is not pulsed.
  - If `aes_done` and the timeout occur in the same cycle, `aes_done` wins.
- SEND: wait until `uart_tx_busy`=0, then pulse `uart_tx_start` with the current byte and go to ACK.
- ACK: wait for `uart_tx_busy`=1, then go to DRAIN.
- DRAIN: wait for `uart_tx_busy`=0, then increment `byte_count`.
  - If this was the last byte, go to FINISH.
  - Otherwise shift the register left by 8 bits and go to SEND.
- FINISH: pulse `done` and go to IDLE.
- Byte order: ciphertext byte 0 is `aes_dout[127:120]`; byte 15 is `aes_dout[7:0]`.
- `aes_done` outside AES_WAIT is ignored.
- Timeout counter width is `$clog2(AES_TIMEOUT)`. It saturates and never wraps.

## Timing
- Reset values: state IDLE, `aes_start`=0, `uart_tx_start`=0, `uart_tx_data`=8'h00, `busy`=0, `done`=0, `error`=0, `byte_count`=0, shift register zero.
- Reset asserted mid-frame aborts immediately: outputs return to their reset values and no `done` or `error` is produced.
- All outputs are registered.
- `start` sampled high at edge N gives `aes_start`=1 during cycle N+1 and `busy`=1 from N+1.
- `aes_done` sampled at edge M gives `uart_tx_start` no earlier than cycle M+2, provided the UART is idle.
- `uart_tx_data` changes only on the edge that raises `uart_tx_start`.
- `done` is high for exactly the cycle after the final falling edge of `uart_tx_busy` is sampled. `busy` falls in the following cycle.
- A new `start` is accepted in the first IDLE cycle after `done` or `error`.

## Configuration
- `SYNC_HEADER_EN` defined:
  - `HEADER_BYTE` is transmitted first, with the full SEND/ACK/DRAIN handshake, before the ciphertext.
  - The frame is 17 bytes; `byte_count` reaches 17 before `done`.
  - The header is sent after `aes_done`, never while AES is pending.
- `SYNC_HEADER_EN` undefined: the frame is 16 bytes; `byte_count` reaches 16 before `done`.

## Test plan
- Reset, then pulse `start`. The AES model returns `aes_dout`=128'h00112233445566778899AABBCCDDEEFF after 20 cycles; the UART model holds busy for 10 cycles per byte. Required: bytes 00,11,…,FF in order, one `done` pulse, `byte_count`=16 (17 with header A5 first under `SYNC_HEADER_EN`).
- AES model never asserts `aes_done`, `AES_TIMEOUT`=1024: exactly one `error` pulse 1024 cycles after `aes_start`, no `uart_tx_start`, `busy`=0 afterwards.
- Pulse `start` again during the SEND phase: no second `aes_start`, and the frame completes unchanged.
- UART model holds `uart_tx_busy`=1 from a prior frame when `aes_done` arrives: `uart_tx_start` is delayed until busy falls, with no lost or duplicated byte.
- Assert `reset`=0 after byte 5 completes: all outputs are zero within the same cycle. After release, a new start sends a full fresh frame beginning at byte 0.
- Assert `aes_done` on the exact timeout cycle: no `error` pulse, and the frame is transmitted normally.
